// File: rtl/jpeg_bit_packer.sv
// jpeg_bit_packer
//
// Output stage of the entropy coder. Each accepted code (a Huffman code plus
// its magnitude bits, 0..32 bits, right-aligned in data_in) is appended
// MSB-first to a continuous bitstream. Each complete 32-bit word is emitted
// for the downstream width adapter. A flush pads the final partial word to a
// word boundary at the end of a scan.
//
// Build option:
//   JPEG_BIT_PACKER_PAD_ONES_EN  defined   -> flush fill bits are 1s (JPEG
//                                              entropy-coded segment padding)
//                                undefined -> flush fill bits are 0s
//
// Ports:
//   clock           rising-edge clock
//   nreset          synchronous reset, active-high
//   data_in_valid   data_in / data_in_length are presented this cycle
//   data_in         code, right-aligned; bits at or above the length are ignored
//   data_in_length  code length 0..32; larger values are treated as 32
//   flush           pad to a word boundary after this cycle's code
//   ready           block accepts data_in_valid / flush this cycle
//   data_out_valid  one-cycle pulse per completed word
//   data_out        packed word, first stream bit at bit 31; held when idle
//   flush_done      one-cycle pulse when a flush completes
//
// The width parameters are fixed at their defaults; they are named only to
// document the relationships between the port widths.

module jpeg_bit_packer #(
    parameter int output_width = 32,
    parameter int code_width   = 32,
    parameter int length_width = 6
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    data_in_valid,
    input  logic [code_width-1:0]   data_in,
    input  logic [length_width-1:0] data_in_length,
    input  logic                    flush,
    output logic                    ready,
    output logic                    data_out_valid,
    output logic [output_width-1:0] data_out,
    output logic                    flush_done
);

    localparam int acc_width = 2 * output_width;

    `ifdef JPEG_BIT_PACKER_PAD_ONES_EN
    localparam logic [output_width-1:0] fill_pattern = '1;
    `else
    localparam logic [output_width-1:0] fill_pattern = '0;
    `endif

    typedef enum logic {
        RUN,
        PAD
    } state_t;

    state_t                  state;
    // Pending stream bits are kept left-aligned: the oldest bit is acc[63].
    // Bits below the top `count` bits are always zero.
    logic [acc_width-1:0]    acc;
    logic [4:0]              count;

    logic [length_width-1:0] len;
    logic                    take;
    logic [acc_width-1:0]    appended;
    logic [acc_width-1:0]    merged;
    logic [6:0]              total;
    logic                    full;
    logic [4:0]              remain;
    logic [acc_width-1:0]    kept;

    // Lengths above code_width are illegal; clamp rather than wrap.
    function automatic logic [length_width-1:0] sat_length(
        input logic [length_width-1:0] l
    );
        if (l > length_width'(code_width))
            return length_width'(code_width);
        return l;
    endfunction

    // Final partial word: the r stream bits followed by fill bits.
    function automatic logic [output_width-1:0] pad_word(
        input logic [output_width-1:0] bits,
        input logic [4:0]              r
    );
        return bits | (fill_pattern >> r);
    endfunction

    always_comb begin
        len  = sat_length(data_in_length);
        take = data_in_valid && ready;

        // Shifting the zero-extended code up by (64 - len) left-aligns it.
        // Any bits at or above len fall off the top, which masks them. For
        // len = 0 the shift is the full width and the result is zero.
        appended = '0;
        if (take)
            appended = {{(acc_width-code_width){1'b0}}, data_in} << (7'(acc_width) - 7'(len));

        merged = acc | (appended >> count);
        total  = 7'(count) + (take ? 7'(len) : 7'd0);
        full   = total >= 7'(output_width);
        // total < 64, so dropping bit 5 is the same as subtracting 32 when full.
        remain = total[4:0];
        kept   = full ? (merged << output_width) : merged;
    end

    always_ff @(posedge clock) begin
        if (nreset) begin
            state          <= RUN;
            acc            <= '0;
            count          <= '0;
            ready          <= 1'b1;
            data_out_valid <= 1'b0;
            data_out       <= '0;
            flush_done     <= 1'b0;
        end else begin
            data_out_valid <= 1'b0;
            flush_done     <= 1'b0;
            case (state)
                RUN: begin
                    acc   <= kept;
                    count <= remain;
                    if (full) begin
                        data_out       <= merged[acc_width-1 -: output_width];
                        data_out_valid <= 1'b1;
                    end
                    if (flush && ready) begin
                        if (remain == 5'd0) begin
                            // Already word-aligned: completes alone or alongside
                            // the word just emitted.
                            flush_done <= 1'b1;
                        end else if (!full) begin
                            // The remainder is padded out this cycle.
                            data_out       <= pad_word(merged[acc_width-1 -: output_width], remain);
                            data_out_valid <= 1'b1;
                            flush_done     <= 1'b1;
                            acc            <= '0;
                            count          <= '0;
                        end else begin
                            // Output slot already taken by a full word; pad next cycle.
                            state <= PAD;
                            ready <= 1'b0;
                        end
                    end
                end
                PAD: begin
                    data_out       <= pad_word(acc[acc_width-1 -: output_width], count);
                    data_out_valid <= 1'b1;
                    flush_done     <= 1'b1;
                    acc            <= '0;
                    count          <= '0;
                    ready          <= 1'b1;
                    state          <= RUN;
                end
                default: begin
                    state <= RUN;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Testbench for jpeg_bit_packer: directed stimulus with a scoreboard queue.
// The stimulus pushes each expected output event (word and/or flush_done,
// plus the cycle it must appear in); a separate monitor pops and compares
// whenever the DUT shows data_out_valid or flush_done.

module tb_jpeg_bit_packer;

    logic        clock;
    logic        nreset;
    logic        data_in_valid;
    logic [31:0] data_in;
    logic [5:0]  data_in_length;
    logic        flush;
    logic        ready;
    logic        data_out_valid;
    logic [31:0] data_out;
    logic        flush_done;

    `ifdef JPEG_BIT_PACKER_PAD_ONES_EN
    localparam logic [31:0] pad_de = 32'hDEFF_FFFF;
    localparam logic [31:0] pad_00 = 32'h00FF_FFFF;
    `else
    localparam logic [31:0] pad_de = 32'hDE00_0000;
    localparam logic [31:0] pad_00 = 32'h0000_0000;
    `endif

    typedef struct {
        logic [31:0] word;
        logic        wv;
        logic        fd;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   failed = 0;
    int   cyc    = 0;

    jpeg_bit_packer dut (
        .clock          (clock),
        .nreset         (nreset),
        .data_in_valid  (data_in_valid),
        .data_in        (data_in),
        .data_in_length (data_in_length),
        .flush          (flush),
        .ready          (ready),
        .data_out_valid (data_out_valid),
        .data_out       (data_out),
        .flush_done     (flush_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every output event must match the head of the scoreboard.
    always @(negedge clock) begin
        if (!nreset && (data_out_valid || flush_done)) begin
            tests++;
            if (q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_output: cycle %0d valid=%b word=%h flush_done=%b, none expected",
                         cyc, data_out_valid, data_out, flush_done);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (data_out_valid !== e.wv || flush_done !== e.fd || cyc != e.cyc ||
                    (e.wv && data_out !== e.word)) begin
                    failed++;
                    $display("FAIL output_event: got cycle %0d valid=%b word=%h flush_done=%b, expected cycle %0d valid=%b word=%h flush_done=%b",
                             cyc, data_out_valid, data_out, flush_done, e.cyc, e.wv, e.word, e.fd);
                end
            end
        end
    end

    task automatic expect_out(input logic [31:0] w, input logic wv, input logic fd, input int lat);
        exp_t e;
        e.word = w;
        e.wv   = wv;
        e.fd   = fd;
        e.cyc  = cyc + lat;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one cycle of input, then return 1 time unit after the accepting edge.
    task automatic send(input logic v, input logic [31:0] d, input logic [5:0] l, input logic f);
        data_in_valid  = v;
        data_in        = d;
        data_in_length = l;
        flush          = f;
        @(posedge clock);
        #1;
        data_in_valid  = 1'b0;
        data_in        = '0;
        data_in_length = '0;
        flush          = 1'b0;
    endtask

    initial begin
        nreset         = 1'b1;
        data_in_valid  = 1'b0;
        data_in        = '0;
        data_in_length = '0;
        flush          = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_valid", 32'(data_out_valid), 32'd0);
        check("reset_data", data_out, 32'd0);
        check("reset_flush_done", 32'(flush_done), 32'd0);
        @(posedge clock);
        #1 nreset = 1'b0;

        // Four byte codes form one word; upper bits of the first code are junk.
        send(1, 32'hFFFF_FFAB, 6'd8, 0);
        send(1, 32'h0000_00CD, 6'd8, 0);
        send(1, 32'h0000_00EF, 6'd8, 0);
        expect_out(32'hABCD_EF12, 1, 0, 1);
        send(1, 32'h0000_0012, 6'd8, 0);

        // Full-width code from an aligned stream.
        expect_out(32'hDEAD_BEEF, 1, 0, 1);
        send(1, 32'hDEAD_BEEF, 6'd32, 0);

        // Still aligned; a zero-length code in between contributes nothing.
        send(1, 32'h0000_0011, 6'd8, 0);
        send(1, 32'hFFFF_FFFF, 6'd0, 0);
        send(1, 32'h0000_0022, 6'd8, 0);
        send(1, 32'h0000_0033, 6'd8, 0);
        expect_out(32'h1122_3344, 1, 0, 1);
        send(1, 32'h0000_0044, 6'd8, 0);

        // Flush with nothing pending: flush_done only.
        expect_out(32'h0, 0, 1, 1);
        send(0, 32'h0, 6'd0, 1);
        check("ready_after_empty_flush", 32'(ready), 32'd1);

        // 40 bits then flush alone: one word, then the padded remainder.
        send(1, 32'h0001_2345, 6'd20, 0);
        expect_out(32'h1234_5ABC, 1, 0, 1);
        send(1, 32'h000A_BCDE, 6'd20, 0);
        expect_out(pad_de, 1, 1, 1);
        send(0, 32'h0, 6'd0, 1);
        check("ready_after_pad_flush", 32'(ready), 32'd1);

        // Emit-plus-pad: two words on consecutive cycles, ready low for one.
        send(1, 32'h3FFF_FFFF, 6'd30, 0);
        expect_out(32'hFFFF_FFFC, 1, 0, 1);
        expect_out(pad_00, 1, 1, 2);
        send(1, 32'h0000_0000, 6'd10, 1);
        check("ready_low_in_pad", 32'(ready), 32'd0);
        send(1, 32'h0000_00FF, 6'd8, 0);
        check("ready_back_after_pad", 32'(ready), 32'd1);

        // The code offered during PAD must have been dropped.
        send(1, 32'h0000_00A1, 6'd8, 0);
        send(1, 32'h0000_00B2, 6'd8, 0);
        send(1, 32'h0000_00C3, 6'd8, 0);
        expect_out(32'hA1B2_C3D4, 1, 0, 1);
        send(1, 32'h0000_00D4, 6'd8, 0);

        // Out-of-range length clamps to 32.
        expect_out(32'hCAFE_BABE, 1, 0, 1);
        send(1, 32'hCAFE_BABE, 6'd40, 0);

        // Reset with 12 bits pending discards them.
        send(1, 32'h0000_0055, 6'd8, 0);
        send(1, 32'h0000_000A, 6'd4, 0);
        nreset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("midword_reset_ready", 32'(ready), 32'd1);
        check("midword_reset_valid", 32'(data_out_valid), 32'd0);
        check("midword_reset_data", data_out, 32'd0);
        check("midword_reset_flush_done", 32'(flush_done), 32'd0);
        @(posedge clock);
        #1 nreset = 1'b0;
        send(1, 32'h0000_0001, 6'd8, 0);
        send(1, 32'h0000_0002, 6'd8, 0);
        send(1, 32'h0000_0003, 6'd8, 0);
        expect_out(32'h0102_0304, 1, 0, 1);
        send(1, 32'h0000_0004, 6'd8, 0);

        repeat (4) @(posedge clock);
        @(negedge clock);
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
